// File: rtl/k_means_pkg.sv
// Shared widths and FSM state encoding for the k-means new-means datapath.
package k_means_pkg;
    localparam int unsigned NUM_CENT   = 8;
    localparam int unsigned NUM_COORD  = 7;
    localparam int unsigned CORD_W     = 13;
    localparam int unsigned ACC_CORD_W = 22;
    localparam int unsigned CNT_W      = 10;
    localparam int unsigned DATA_W     = NUM_COORD * CORD_W;
    localparam int unsigned ACC_W      = NUM_COORD * ACC_CORD_W;
    localparam int unsigned IDX_W      = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        DIVIDE = 3'd2,
        EMIT   = 3'd3,
        DONE   = 3'd4
    } state_e;
endpackage

// File: rtl/new_means_calculation_block_divider.sv
// Restoring divider, one quotient bit per cycle MSB first, quotient saturated to QUOT_W bits.
// The first step is folded into the start cycle so the last step lands DIVIDEND_W-1 cycles later.
module seq_divider
    import k_means_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = ACC_CORD_W,
    parameter int unsigned DIVISOR_W  = CNT_W,
    parameter int unsigned QUOT_W     = CORD_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [QUOT_W-1:0]     quotient_c,
    output logic                  done
);
    localparam int unsigned STEP_W = $clog2(DIVIDEND_W + 1);

    logic [DIVIDEND_W-1:0] dq_q;
    logic [DIVISOR_W-1:0]  rem_q;
    logic [DIVISOR_W-1:0]  div_q;
    logic [STEP_W-1:0]     steps_q;

    logic [DIVIDEND_W-1:0] dq_in;
    logic [DIVISOR_W-1:0]  rem_in;
    logic [DIVISOR_W-1:0]  div_in;
    logic [DIVISOR_W-1:0]  rem_nxt;
    logic [DIVISOR_W:0]    trial;
    logic                  qbit;

    // Remainder stays below the divisor, so the trial value needs one extra bit only.
    always_comb begin
        dq_in   = start ? dividend : dq_q;
        rem_in  = start ? '0 : rem_q;
        div_in  = start ? divisor : div_q;
        trial   = {rem_in, dq_in[DIVIDEND_W-1]};
        qbit    = (trial >= {1'b0, div_in});
        rem_nxt = qbit ? DIVISOR_W'(trial - {1'b0, div_in}) : trial[DIVISOR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dq_q    <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            steps_q <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                dq_q    <= {dq_in[DIVIDEND_W-2:0], qbit};
                rem_q   <= rem_nxt;
                div_q   <= div_in;
                steps_q <= STEP_W'(DIVIDEND_W - 1);
            end else if (steps_q != '0) begin
                dq_q    <= {dq_in[DIVIDEND_W-2:0], qbit};
                rem_q   <= rem_nxt;
                steps_q <= steps_q - STEP_W'(1);
                done    <= (steps_q == STEP_W'(1));
            end
        end
    end

    assign quotient_c = (|dq_q[DIVIDEND_W-1:QUOT_W]) ? '1 : dq_q[QUOT_W-1:0];
endmodule

// File: rtl/new_means_calculation_block.sv
// Walks the 8 centroids: reads each sum/count, divides 7 coordinates in parallel and emits the new mean.
module new_means_calculation_block
    import k_means_pkg::*;
#(
    parameter int unsigned dataWidth        = DATA_W,
    parameter int unsigned cordinate_width  = CORD_W,
    parameter int unsigned accum_cord_width = ACC_CORD_W,
    parameter int unsigned accum_width      = ACC_W,
    parameter int unsigned count_width      = CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic [IDX_W-1:0]       acc_rd_idx,
    input  logic [accum_width-1:0] acc_sum_in,
    input  logic [count_width-1:0] acc_count_in,
    input  logic [dataWidth-1:0]   old_centroid_in,
    output logic [dataWidth-1:0]   new_centroid_out,
    output logic [IDX_W-1:0]       cent_num,
    output logic                   convergence_reg_en,
    output logic                   done
);
    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       k_q, k_d;
    logic [count_width-1:0] count_q;
    logic [dataWidth-1:0]   old_q;
    logic [NUM_COORD-1:0]   div_done;
    logic [dataWidth-1:0]   quot_vec;
    logic                   load_c;

    logic                   busy_d, conv_d, done_d;
    logic [IDX_W-1:0]       idx_d, num_d;
    logic [dataWidth-1:0]   cent_d;

    assign load_c = (state_q == LOAD);

    for (genvar i = 0; i < NUM_COORD; i++) begin : g_div
        seq_divider #(
            .DIVIDEND_W (accum_cord_width),
            .DIVISOR_W  (count_width),
            .QUOT_W     (cordinate_width)
        ) u_div (
            .clk        (clk),
            .rst        (rst),
            .start      (load_c),
            .dividend   (acc_sum_in[i*accum_cord_width +: accum_cord_width]),
            .divisor    (acc_count_in),
            .quotient_c (quot_vec[i*cordinate_width +: cordinate_width]),
            .done       (div_done[i])
        );
    end

    // State, index and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= IDLE;
            k_q                <= '0;
            busy               <= 1'b0;
            acc_rd_idx         <= '0;
            new_centroid_out   <= '0;
            cent_num           <= '0;
            convergence_reg_en <= 1'b0;
            done               <= 1'b0;
        end else begin
            state_q            <= state_d;
            k_q                <= k_d;
            busy               <= busy_d;
            acc_rd_idx         <= idx_d;
            new_centroid_out   <= cent_d;
            cent_num           <= num_d;
            convergence_reg_en <= conv_d;
            done               <= done_d;
        end
    end

    // Count and old centroid are kept for the zero-member fallback.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            old_q   <= '0;
        end else if (load_c) begin
            count_q <= acc_count_in;
            old_q   <= old_centroid_in;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    k_d     = '0;
                end
            end
            LOAD:   state_d = DIVIDE;
            DIVIDE: begin
                if (&div_done) state_d = EMIT;
            end
            EMIT: begin
                if (k_q == IDX_W'(NUM_CENT - 1)) begin
                    state_d = DONE;
                end else begin
                    state_d = LOAD;
                    k_d     = k_q + IDX_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs follow the next state so they line up with it cycle for cycle.
    always_comb begin
        busy_d = (state_d != IDLE);
        idx_d  = (state_d == IDLE) ? '0 : k_d;
        conv_d = (state_d == EMIT);
        done_d = (state_d == DONE);
        cent_d = new_centroid_out;
        num_d  = cent_num;
        if (state_d == EMIT) begin
            num_d  = k_q;
            cent_d = (count_q == '0) ? old_q : quot_vec;
        end
    end
endmodule

// File: tb/tb_new_means_calculation_block.sv
// Scoreboard bench: expected centroids are queued at start and popped on each convergence strobe.
module tb_new_means_calculation_block;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         busy;
    logic [2:0]   acc_rd_idx;
    logic [153:0] acc_sum_in;
    logic [9:0]   acc_count_in;
    logic [90:0]  old_centroid_in;
    logic [90:0]  new_centroid_out;
    logic [2:0]   cent_num;
    logic         convergence_reg_en;
    logic         done;

    typedef struct {
        logic [2:0]  k;
        logic [90:0] c;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [21:0] sums[8][7];
    logic [9:0]  cnts[8];
    logic [90:0] olds[8];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          edge_cnt = 0;

    new_means_calculation_block dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .busy               (busy),
        .acc_rd_idx         (acc_rd_idx),
        .acc_sum_in         (acc_sum_in),
        .acc_count_in       (acc_count_in),
        .old_centroid_in    (old_centroid_in),
        .new_centroid_out   (new_centroid_out),
        .cent_num           (cent_num),
        .convergence_reg_en (convergence_reg_en),
        .done               (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Accumulator memory model answering the read index combinationally
    always_comb begin
        for (int i = 0; i < 7; i++) acc_sum_in[i*22 +: 22] = sums[acc_rd_idx][i];
        acc_count_in    = cnts[acc_rd_idx];
        old_centroid_in = olds[acc_rd_idx];
    end

    function automatic logic [90:0] model(input int k);
        logic [90:0] r;
        longint      q;
        if (cnts[k] == 10'd0) return olds[k];
        for (int i = 0; i < 7; i++) begin
            q = longint'(sums[k][i]) / longint'(cnts[k]);
            if (q > 8191) q = 8191;
            r[i*13 +: 13] = 13'(q);
        end
        return r;
    endfunction

    function automatic logic [90:0] rand91();
        return 91'({$urandom, $urandom, $urandom});
    endfunction

    // Runs one start; rst pulses at rel cycle abort_rel (0 = none), start re-pulses at spur_a/spur_b.
    task automatic run_scenario(input string tag, input int abort_rel, input int spur_a, input int spur_b);
        exp_t        e;
        int          t, sc, rel, ndone, last_rel, kk;
        logic [90:0] last_c;
        logic        exp_busy;
        logic [2:0]  exp_idx;
        sb.delete();
        @(negedge clk);
        start = 1'b1;
        t = edge_cnt + 1;
        for (int k = 0; k < 8; k++) begin
            if (abort_rel == 0 || 24 + 24 * k <= abort_rel) begin
                e.k = 3'(k);
                e.c = model(k);
                e.cyc = t + 24 + 24 * k;
                sb.push_back(e);
                last_c = e.c;
            end
        end
        ndone = 0;
        last_rel = (abort_rel == 0) ? 200 : abort_rel + 40;
        for (int r = 1; r <= last_rel; r++) begin
            @(negedge clk);
            sc = edge_cnt + 1;
            rel = sc - t;
            start = (rel == spur_a || rel == spur_b);
            rst = (abort_rel != 0 && rel == abort_rel);
            if (convergence_reg_en) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s_strobe: unexpected strobe at rel %0d cent_num %0d, required none", tag, rel, cent_num);
                end else begin
                    e = sb.pop_front();
                    if (cent_num !== e.k || new_centroid_out !== e.c || sc != e.cyc) begin
                        n_fail++;
                        $display("FAIL %s_centroid: got k=%0d c=%h rel=%0d, required k=%0d c=%h rel=%0d",
                                 tag, cent_num, new_centroid_out, rel, e.k, e.c, e.cyc - t);
                    end
                end
            end
            if (done) begin
                ndone++;
                n_cmp++;
                if (abort_rel != 0 || rel != 193) begin
                    n_fail++;
                    $display("FAIL %s_done: done at rel %0d, required rel 193 without abort", tag, rel);
                end
            end
            exp_busy = (rel <= 193) && (abort_rel == 0 || rel <= abort_rel);
            kk = (rel - 1) / 24;
            if (kk > 7) kk = 7;
            exp_idx = exp_busy ? 3'(kk) : 3'd0;
            n_cmp++;
            if (busy !== exp_busy || acc_rd_idx !== exp_idx) begin
                n_fail++;
                $display("FAIL %s_busy_idx: rel %0d got busy=%b idx=%0d, required busy=%b idx=%0d",
                         tag, rel, busy, acc_rd_idx, exp_busy, exp_idx);
            end
        end
        start = 1'b0;
        rst = 1'b0;
        n_cmp++;
        if (sb.size() != 0 || ndone != ((abort_rel == 0) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s_totals: %0d strobes missing, %0d done pulses, required 0 missing and %0d done",
                     tag, sb.size(), ndone, (abort_rel == 0) ? 1 : 0);
        end
        n_cmp++;
        if (abort_rel == 0 && new_centroid_out !== last_c) begin
            n_fail++;
            $display("FAIL %s_hold: got %h, required last emitted %h", tag, new_centroid_out, last_c);
        end else if (abort_rel != 0 && new_centroid_out !== 91'd0) begin
            n_fail++;
            $display("FAIL %s_cleared: got %h, required 0 after reset", tag, new_centroid_out);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 7; i++) sums[k][i] = 22'd0;
            cnts[k] = 10'd0;
            olds[k] = 91'd0;
        end
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, acc_rd_idx, cent_num, convergence_reg_en, done} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got busy=%b idx=%0d num=%0d en=%b done=%b, required all 0",
                     busy, acc_rd_idx, cent_num, convergence_reg_en, done);
        end
        n_cmp++;
        if (new_centroid_out !== 91'd0) begin
            n_fail++;
            $display("FAIL reset_centroid: got %h, required 0", new_centroid_out);
        end
        start = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || convergence_reg_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b en=%b, required 0 0", busy, convergence_reg_en);
        end
    endtask

    task automatic test_uniform();
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 7; i++) sums[k][i] = 22'd700;
            cnts[k] = 10'd7;
            olds[k] = rand91();
        end
        run_scenario("uniform", 0, 0, 0);
    endtask

    task automatic test_values();
        for (int k = 0; k < 8; k++) begin
            olds[k] = rand91();
            cnts[k] = 10'($urandom_range(1, 1023));
            for (int i = 0; i < 7; i++) sums[k][i] = 22'($urandom);
        end
        for (int i = 0; i < 7; i++) begin
            sums[0][i] = 22'd10;
            olds[1][i*13 +: 13] = 13'(i + 1);
            sums[2][i] = 22'd4194303;
            sums[3][i] = 22'(i * 1000 + 7);
            sums[4][i] = 22'(40950 + 2 * i);
            sums[5][i] = 22'd4194303;
        end
        cnts[0] = 10'd3;
        cnts[1] = 10'd0;
        cnts[2] = 10'd1;
        cnts[3] = 10'd9;
        cnts[4] = 10'd5;
        cnts[5] = 10'd1023;
        run_scenario("values", 0, 0, 0);
    endtask

    task automatic test_reset_abort();
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 7; i++) sums[k][i] = 22'($urandom_range(0, 200000));
            cnts[k] = 10'($urandom_range(1, 1023));
            olds[k] = rand91();
        end
        run_scenario("abort", 80, 0, 0);
        run_scenario("after_abort", 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 7; i++) sums[k][i] = 22'($urandom);
            cnts[k] = (k == 6) ? 10'd0 : 10'($urandom_range(1, 1023));
            olds[k] = rand91();
        end
        run_scenario("ignored_start", 0, 50, 193);
        run_scenario("back_to_back", 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_values();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
